// File: rtl/text_cell_fetch.sv
// Video-side text row fetcher: reads cells from the screen RAM video port,
// buffers them in a show-ahead FIFO and streams them out with a last-of-row tag.
module text_cell_fetch #(
  parameter  int TEXT_CELL_COUNT = 16384,
  parameter  int FIFO_DEPTH      = 8,
  localparam int AWID            = $clog2(TEXT_CELL_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            frame_start_i,
  input  logic [AWID-1:0] base_adr_i,
  input  logic [7:0]      cols_i,
  input  logic            row_req_i,
  input  logic            row_adv_i,
  output logic            ram_cs_o,
  output logic [AWID-1:0] ram_adr_o,
  input  logic [31:0]     ram_dat_i,
  output logic [31:0]     cell_o,
  output logic            cell_vld_o,
  output logic            cell_last_o,
  input  logic            cell_rdy_i,
  output logic            busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          r_state, w_state_next;
  logic [AWID-1:0] r_row_ptr, r_start;
  logic [7:0]      r_col, r_ncols;
  logic            r_inflight, r_inflight_last;
  logic [31:0]     r_mem_dat  [FIFO_DEPTH];
  logic            r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_accept, w_credit, w_issue, w_issue_last, w_push, w_pop;
  logic [CW:0]     w_used;

  // Reads already in flight reserve a FIFO slot so a return can never overflow.
  assign w_used       = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_credit     = w_used < (CW+1)'(FIFO_DEPTH);
  assign w_accept     = (r_state == IDLE) & row_req_i & (cols_i != 8'd0) & ~frame_start_i;
  assign w_issue_last = (r_col == r_ncols - 8'd1);
  assign w_push       = r_inflight & ~frame_start_i;
  assign w_pop        = (r_count != '0) & cell_rdy_i;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    if (frame_start_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_accept) w_state_next = FETCH;
        FETCH: if (w_credit) begin
          w_issue = 1'b1;
          if (w_issue_last) w_state_next = DRAIN;
        end
        DRAIN: if (r_inflight) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= IDLE;
      r_row_ptr       <= '0;
      r_start         <= '0;
      r_col           <= '0;
      r_ncols         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
    end else begin
      r_state         <= w_state_next;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      if (frame_start_i) begin
        r_row_ptr <= base_adr_i;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
      end else begin
        if (row_adv_i) r_row_ptr <= r_row_ptr + AWID'(cols_i);
        if (w_push)    r_wr_ptr  <= r_wr_ptr + PW'(1);
        if (w_pop)     r_rd_ptr  <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_accept) begin
        r_start <= r_row_ptr;
        r_ncols <= cols_i;
        r_col   <= '0;
      end else if (w_issue) begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_dat[r_wr_ptr]  <= ram_dat_i;
      r_mem_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  assign ram_cs_o    = w_issue;
  assign ram_adr_o   = r_start + AWID'(r_col);
  assign busy_o      = (r_state != IDLE);
  assign cell_vld_o  = (r_count != '0);
  assign cell_o      = r_mem_dat[r_rd_ptr];
  assign cell_last_o = cell_vld_o & r_mem_last[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_push |-> (r_count != CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_text_cell_fetch.sv
// Directed bench for text_cell_fetch with a 1-cycle-latency RAM model whose
// data word encodes its own address.
module tb_text_cell_fetch;
  localparam int AWID = 14;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            frame_start_i = 1'b0;
  logic [AWID-1:0] base_adr_i = '0;
  logic [7:0]      cols_i = '0;
  logic            row_req_i = 1'b0;
  logic            row_adv_i = 1'b0;
  logic            ram_cs_o;
  logic [AWID-1:0] ram_adr_o;
  logic [31:0]     ram_dat_i = '0;
  logic [31:0]     cell_o;
  logic            cell_vld_o, cell_last_o;
  logic            cell_rdy_i = 1'b0;
  logic            busy_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_vld_cyc = -1;
  logic [AWID-1:0] adr_q[$];
  int              adr_cyc_q[$];
  logic [31:0]     cell_q[$];
  logic            last_q[$];

  text_cell_fetch #(.TEXT_CELL_COUNT(16384), .FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_start_i(frame_start_i),
    .base_adr_i(base_adr_i), .cols_i(cols_i), .row_req_i(row_req_i),
    .row_adv_i(row_adv_i), .ram_cs_o(ram_cs_o), .ram_adr_o(ram_adr_o),
    .ram_dat_i(ram_dat_i), .cell_o(cell_o), .cell_vld_o(cell_vld_o),
    .cell_last_o(cell_last_o), .cell_rdy_i(cell_rdy_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] pat(input logic [AWID-1:0] a);
    return {8'hC3, a[7:0], 2'b01, a};
  endfunction

  always @(posedge clk_i) if (ram_cs_o) ram_dat_i <= pat(ram_adr_o);

  // Observes the DUT mid-cycle; inputs only change just after the rising edge.
  always begin
    @(negedge clk_i);
    #1;
    cyc++;
    if (rst_ni) begin
      if (ram_cs_o) begin
        adr_q.push_back(ram_adr_o);
        adr_cyc_q.push_back(cyc);
      end
      if (cell_vld_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (cell_vld_o && cell_rdy_i) begin
        cell_q.push_back(cell_o);
        last_q.push_back(cell_last_o);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear();
    adr_q.delete(); adr_cyc_q.delete(); cell_q.delete(); last_q.delete();
    first_vld_cyc = -1;
  endtask

  task automatic frame(input logic [AWID-1:0] base);
    base_adr_i = base; frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
  endtask

  task automatic request(input logic [7:0] n);
    cols_i = n; row_req_i = 1'b1;
    step();
    row_req_i = 1'b0;
  endtask

  // Checks a completed row: n addresses from start, n cells in order, last only on the final one.
  task automatic check_row(input string name, input logic [AWID-1:0] start, input int n);
    logic [AWID-1:0] ea;
    n_vec++;
    if (adr_q.size() != n || cell_q.size() != n) begin
      n_bad++;
      $display("FAIL %s_count: reads %0d cells %0d, expected %0d each", name, adr_q.size(), cell_q.size(), n);
    end
    for (int i = 0; i < n && i < adr_q.size() && i < cell_q.size(); i++) begin
      ea = start + AWID'(i);
      n_vec++;
      if (adr_q[i] !== ea || cell_q[i] !== pat(ea) || last_q[i] !== (i == n - 1)) begin
        n_bad++;
        $display("FAIL %s_item%0d: adr %h cell %h last %b, expected adr %h cell %h last %b",
                 name, i, adr_q[i], cell_q[i], last_q[i], ea, pat(ea), (i == n - 1));
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step(); step();
    n_vec++;
    if ({ram_cs_o, cell_vld_o, cell_last_o, busy_o} !== 4'b0000 || ram_adr_o !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: cs/vld/last/busy %b%b%b%b adr %h, expected 0000 adr 0",
               ram_cs_o, cell_vld_o, cell_last_o, busy_o, ram_adr_o);
    end
    rst_ni = 1'b1;
    step();
    n_vec++;
    if (busy_o !== 1'b0 || cell_vld_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy %b vld %b, expected 0 0", busy_o, cell_vld_o);
    end
  endtask

  task automatic test_full_row();
    int req_cyc;
    cell_rdy_i = 1'b1;
    frame(14'h0100);
    clear();
    req_cyc = cyc + 1;
    request(8'd80);
    repeat (80) step();
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL full_busy80: busy %b, expected 1", busy_o);
    end
    step();
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL full_busy81: busy %b, expected 0", busy_o);
    end
    repeat (4) step();
    check_row("full", 14'h0100, 80);
    n_vec++;
    if (adr_cyc_q.size() != 80 || adr_cyc_q[0] != req_cyc + 1 || adr_cyc_q[79] != req_cyc + 80) begin
      n_bad++;
      $display("FAIL full_issue_timing: first/last issue cycle %0d/%0d, expected %0d/%0d",
               adr_cyc_q.size() > 0 ? adr_cyc_q[0] : -1, adr_cyc_q.size() > 79 ? adr_cyc_q[79] : -1,
               req_cyc + 1, req_cyc + 80);
    end
    n_vec++;
    if (first_vld_cyc != req_cyc + 3) begin
      n_bad++;
      $display("FAIL full_first_vld: cycle %0d, expected %0d", first_vld_cyc, req_cyc + 3);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    cell_rdy_i = 1'b0;
    frame(14'h0100);
    clear();
    request(8'd80);
    repeat (20) step();
    n_vec++;
    if (adr_q.size() != 8 || ram_cs_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_reads: %0d issued cs %b, expected 8 issued cs 0", adr_q.size(), ram_cs_o);
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (cell_vld_o !== 1'b1 || cell_o !== pat(14'h0100) || cell_last_o !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: vld %b cell %h last %b, expected 1 %h 0",
                 k, cell_vld_o, cell_o, cell_last_o, pat(14'h0100));
      end
      step();
    end
    cell_rdy_i = 1'b1;
    guard = 0;
    while ((busy_o || cell_vld_o) && guard < 300) begin
      step();
      guard++;
    end
    n_vec++;
    if (guard >= 300) begin
      n_bad++; $display("FAIL bp_timeout: still busy after %0d cycles, expected idle", guard);
    end
    check_row("bp", 14'h0100, 80);
  endtask

  task automatic test_wrap();
    cell_rdy_i = 1'b1;
    frame(14'h3FFE);
    clear();
    request(8'd4);
    repeat (10) step();
    check_row("wrap", 14'h3FFE, 4);
    n_vec++;
    if (adr_q.size() == 4 && adr_q[2] !== 14'h0000) begin
      n_bad++; $display("FAIL wrap_zero: adr %h, expected 0000", adr_q[2]);
    end
  endtask

  task automatic test_frame_abort();
    cell_rdy_i = 1'b0;
    frame(14'h0100);
    clear();
    request(8'd80);
    repeat (5) step();
    n_vec++;
    if (cell_vld_o !== 1'b1 || ram_cs_o !== 1'b1) begin
      n_bad++; $display("FAIL abort_pre: vld %b cs %b, expected 1 1", cell_vld_o, ram_cs_o);
    end
    base_adr_i = 14'h0200;
    frame_start_i = 1'b1;
    @(negedge clk_i);
    #2;
    n_vec++;
    if (ram_cs_o !== 1'b0) begin
      n_bad++; $display("FAIL abort_cs: cs %b, expected 0", ram_cs_o);
    end
    step();
    frame_start_i = 1'b0;
    n_vec++;
    if (cell_vld_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL abort_flush: vld %b busy %b, expected 0 0", cell_vld_o, busy_o);
    end
    cell_rdy_i = 1'b1;
    clear();
    repeat (4) step();
    n_vec++;
    if (cell_q.size() != 0 || adr_q.size() != 0) begin
      n_bad++;
      $display("FAIL abort_stale: cells %0d reads %0d, expected 0 0", cell_q.size(), adr_q.size());
    end
    clear();
    request(8'd4);
    repeat (8) step();
    check_row("abort_next", 14'h0200, 4);
  endtask

  task automatic test_row_adv();
    cell_rdy_i = 1'b1;
    frame(14'h0000);
    cols_i = 8'd80;
    row_adv_i = 1'b1;
    repeat (3) step();
    row_adv_i = 1'b0;
    clear();
    request(8'd2);
    repeat (6) step();
    check_row("adv3", 14'd240, 2);
    cols_i = 8'd80;
    row_adv_i = 1'b1;
    frame(14'h0050);
    row_adv_i = 1'b0;
    clear();
    request(8'd1);
    repeat (5) step();
    check_row("adv_frame", 14'h0050, 1);
  endtask

  task automatic test_ignored();
    cell_rdy_i = 1'b1;
    clear();
    request(8'd0);
    repeat (3) step();
    n_vec++;
    if (busy_o !== 1'b0 || adr_q.size() != 0) begin
      n_bad++; $display("FAIL ign_zero: busy %b reads %0d, expected 0 0", busy_o, adr_q.size());
    end
    clear();
    request(8'd3);
    request(8'd5);
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL ign_busy: busy %b, expected 1", busy_o);
    end
    repeat (10) step();
    check_row("ign_busy", 14'h0050, 3);
    n_vec++;
    if (busy_o !== 1'b0 || ram_cs_o !== 1'b0) begin
      n_bad++; $display("FAIL ign_idle: busy %b cs %b, expected 0 0", busy_o, ram_cs_o);
    end
  endtask

  task automatic test_reset_midfetch();
    cell_rdy_i = 1'b0;
    clear();
    request(8'd80);
    repeat (4) step();
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({ram_cs_o, cell_vld_o, cell_last_o, busy_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_mid: cs/vld/last/busy %b%b%b%b, expected 0000",
               ram_cs_o, cell_vld_o, cell_last_o, busy_o);
    end
    step();
    rst_ni = 1'b1;
    cell_rdy_i = 1'b1;
    clear();
    repeat (5) step();
    n_vec++;
    if (cell_q.size() != 0 || adr_q.size() != 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after: cells %0d reads %0d busy %b, expected 0 0 0",
               cell_q.size(), adr_q.size(), busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_backpressure();
    test_wrap();
    test_frame_abort();
    test_row_adv();
    test_ignored();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
